// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encodings and byte-level helpers for the iterative round datapath.
// Byte order: bits [127:120] hold state byte 0 (column-major).
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    typedef logic [127:0] block_t;

    typedef logic [1:0] fsm_t;
    localparam fsm_t IDLE  = 2'd0;
    localparam fsm_t ROUND = 2'd1;
    localparam fsm_t DONE  = 2'd2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Round key rc from round key rc-1.
    function automatic block_t key_gen(input logic [3:0] rc, input block_t key);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({key[23:0], key[31:24]}) ^ {rcon(rc), 24'h0};
        w0 = key[127:96] ^ t;
        w1 = key[95:64] ^ w0;
        w2 = key[63:32] ^ w1;
        w3 = key[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One full AES middle round: SubBytes, ShiftRows, MixColumns and AddRoundKey, purely combinational.
module aes_round
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t rk,
    output block_t state_out
);

    block_t sb, sr, mc;

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
        end
    end

    // Row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
    end

    assign state_out = mc ^ rk;

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES-128 front end: initial AddRoundKey plus rounds 1..NR-1, one round per clock,
// with on-the-fly key expansion; hands the round NR-1 state and key to the last-round stage.
module aes_round_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] round_out,
    output logic [127:0] key_out,
    output logic [3:0]   rc_out
);

    localparam logic [3:0] LAST_CNT = 4'(NR - 1);

    fsm_t       fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    block_t     state_q, state_d;
    block_t     key_q, key_d;
    block_t     round_key, round_next;

    assign round_key = key_gen(cnt_q, key_q);

    aes_round u_round (
        .state_in  (state_q),
        .rk        (round_key),
        .state_out (round_next)
    );

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        key_d   = key_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ key_in;
                    key_d   = key_in;
                    cnt_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_next;
                key_d   = round_key;
                // Counter parks at NR-1 so it never leaves the valid round range.
                if (cnt_q == LAST_CNT) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign round_out = state_q;
    assign key_out   = key_q;
    assign rc_out    = 4'(NR);

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: FIPS-197 vectors plus random jobs against a GF(2^8)-arithmetic model.
module tb_aes_round_iter;

    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R9_A  = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K9_A  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] round_out;
    logic [127:0] key_out;
    logic [3:0]   rc_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    aes_round_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plaintext (plaintext),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .round_out (round_out),
        .key_out   (key_out),
        .rc_out    (rc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (field arithmetic, no tables) ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] m_rcon(input int j);
        logic [7:0] r = 8'h01;
        for (int i = 1; i < j; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [8];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 8; i++) begin
            t = w[i-1];
            if (i == 4) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4], w[5], w[6], w[7]};
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] st, input logic [127:0] rk,
                                             input bit last);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = m_sbox(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[r+4*c];
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = gf_mul(8'h02, a[r]) ^ gf_mul(8'h03, a[(r+1)%4]) ^
                               a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                 output logic [127:0] r9, output logic [127:0] k9,
                                 output logic [127:0] ct);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        for (int r = 1; r <= 9; r++) begin
            k = key_step(k, m_rcon(r));
            s = m_round(s, k, 1'b0);
        end
        r9 = s;
        k9 = k;
        ct = m_round(s, key_step(k, m_rcon(10)), 1'b1);
    endtask

    // Bench-side last round fed from the DUT hand-off outputs.
    function automatic logic [127:0] lastround(input logic [127:0] r, input logic [127:0] k);
        return m_round(r, key_step(k, m_rcon(10)), 1'b1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_job(input logic [127:0] pt, input logic [127:0] key);
        int n = 0;
        plaintext = pt;
        key_in    = key;
        in_valid  = 1'b1;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) n = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_hs: ready/valid=%b want 10", {in_ready, out_valid});
        end
        total++;
        if ({round_out, key_out} !== 256'h0) begin
            bad++;
            $display("FAIL reset_data: round=%h key=%h want 0", round_out, key_out);
        end
        total++;
        if (rc_out !== 4'd10) begin
            bad++;
            $display("FAIL rc_out: got %0d want 10", rc_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_idle: ready/valid=%b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_fips();
        int n;
        start_job(PT_A, KEY_A);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready: in_ready=%b want 0", in_ready);
        end
        wait_out(n);
        total++;
        if (n !== 9) begin
            bad++;
            $display("FAIL latency: out_valid after %0d edges past accept, want 9", n);
        end
        total++;
        if (round_out !== R9_A || key_out !== K9_A) begin
            bad++;
            $display("FAIL fips_r9: round=%h key=%h want %h %h", round_out, key_out, R9_A, K9_A);
        end
        total++;
        if (lastround(round_out, key_out) !== CT_A) begin
            bad++;
            $display("FAIL fips_ct: got %h want %h", lastround(round_out, key_out), CT_A);
        end
        release_out();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL fips_release: ready/valid=%b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_job(PT_A, KEY_A);
        wait_out(n);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({out_valid, in_ready} !== 2'b10 || round_out !== R9_A || key_out !== K9_A) begin
                bad++;
                $display("FAIL backpressure[%0d]: v/r=%b round=%h key=%h want 10 %h %h",
                         i, {out_valid, in_ready}, round_out, key_out, R9_A, K9_A);
            end
        end
        release_out();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release: ready/valid=%b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_busy_input();
        int n;
        start_job(PT_A, KEY_A);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL busy_latency: %0d extra edges, want 1", n);
        end
        total++;
        if (round_out !== R9_A || key_out !== K9_A) begin
            bad++;
            $display("FAIL busy_result: round=%h key=%h want %h %h", round_out, key_out, R9_A, K9_A);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int n;
        start_job(PT_A, KEY_A);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01 || round_out !== 128'h0 || key_out !== 128'h0) begin
            bad++;
            $display("FAIL mid_reset: v/r=%b round=%h key=%h want 01 0 0",
                     {out_valid, in_ready}, round_out, key_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL mid_reset_release: v/r=%b want 01", {out_valid, in_ready});
        end
        start_job(PT_A, KEY_A);
        wait_out(n);
        total++;
        if (n !== 9 || round_out !== R9_A || key_out !== K9_A) begin
            bad++;
            $display("FAIL reset_rerun: n=%0d round=%h key=%h want 9 %h %h",
                     n, round_out, key_out, R9_A, K9_A);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int           n, ta, tb;
        bit           got_a = 0;
        logic [127:0] ra = '0, ka = '0;
        out_ready = 1'b1;
        start_job(PT_A, KEY_A);
        ta = cyc;
        plaintext = PT_B;
        key_in    = KEY_B;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin
            if (out_valid) begin
                got_a = 1;
                ra    = round_out;
                ka    = key_out;
            end
            tick();
            n++;
        end
        tick();
        tb = cyc;
        in_valid = 1'b0;
        total++;
        if (tb - ta !== 11) begin
            bad++;
            $display("FAIL issue_interval: got %0d want 11", tb - ta);
        end
        total++;
        if (!got_a || lastround(ra, ka) !== CT_A) begin
            bad++;
            $display("FAIL b2b_first: seen=%0d ct=%h want %h", got_a, lastround(ra, ka), CT_A);
        end
        wait_out(n);
        total++;
        if (n !== 9 || lastround(round_out, key_out) !== CT_B) begin
            bad++;
            $display("FAIL b2b_second: n=%0d ct=%h want 9 %h", n, lastround(round_out, key_out),
                     CT_B);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int           n;
        logic [127:0] pt, key, r9, k9, ct;
        for (int j = 0; j < 6; j++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            model_encrypt(pt, key, r9, k9, ct);
            start_job(pt, key);
            wait_out(n);
            total++;
            if (n !== 9) begin
                bad++;
                $display("FAIL rand_latency[%0d]: got %0d want 9", j, n);
            end
            total++;
            if (round_out !== r9 || key_out !== k9) begin
                bad++;
                $display("FAIL rand_r9[%0d]: round=%h key=%h want %h %h", j, round_out, key_out,
                         r9, k9);
            end
            total++;
            if (lastround(round_out, key_out) !== ct) begin
                bad++;
                $display("FAIL rand_ct[%0d]: got %h want %h", j, lastround(round_out, key_out), ct);
            end
            release_out();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key_in    = '0;
        test_reset();
        test_fips();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
